// File: rtl/secded_pkg.sv
// Shared SECDED definitions for the data-memory responder.
// Codeword layout (39 bits):
//   bit 0               overall parity over positions 1..38
//   bits 1,2,4,8,16,32  Hamming parity bits
//   remaining positions data bits 0..31 in ascending order
// Contents: width constants, per-parity-bit coverage masks, data scatter/gather
// helpers, secded_encode, and the scrub FSM state type.
package secded_pkg;

  localparam int CW_W    = 39;
  localparam int DATA_W  = 32;
  localparam int PAR_N   = 6;
  localparam int MAX_POS = CW_W - 1;

  typedef enum logic {
    SCRUB_IDLE = 1'b0,
    SCRUB_PEND = 1'b1
  } scrub_state_e;

  // Positions 1..38 whose index has bit k set, i.e. what Hamming parity bit
  // 2**k covers. The mask also includes position 2**k itself, so the same
  // mask yields the syndrome bit on decode.
  function automatic logic [CW_W-1:0] pos_mask(input int k);
    logic [CW_W-1:0] m;
    m = '0;
    for (int p = 1; p < CW_W; p++) begin
      if (((p >> k) & 1) != 0) begin
        m = m | (CW_W'(1) << p);
      end
    end
    return m;
  endfunction

  localparam logic [PAR_N-1:0][CW_W-1:0] PMASK = {
    pos_mask(5), pos_mask(4), pos_mask(3), pos_mask(2), pos_mask(1), pos_mask(0)
  };

  // Data bits into the non-power-of-two positions 3,5-7,9-15,17-31,33-38.
  function automatic logic [CW_W-1:0] place_data(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw        = '0;
    cw[3]     = d[0];
    cw[7:5]   = d[3:1];
    cw[15:9]  = d[10:4];
    cw[31:17] = d[25:11];
    cw[38:33] = d[31:26];
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    return {cw[38:33], cw[31:17], cw[15:9], cw[7:5], cw[3]};
  endfunction

  // Parity bits are still zero when each one is computed, and mask k covers
  // no other parity position, so evaluation order does not matter.
  function automatic logic [CW_W-1:0] secded_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw     = place_data(d);
    cw[1]  = ^(cw & PMASK[0]);
    cw[2]  = ^(cw & PMASK[1]);
    cw[4]  = ^(cw & PMASK[2]);
    cw[8]  = ^(cw & PMASK[3]);
    cw[16] = ^(cw & PMASK[4]);
    cw[32] = ^(cw & PMASK[5]);
    cw[0]  = ^cw[CW_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/secded_dmem_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the SECDED RAM
// responder (slave).
//   WE, RE   store / load strobes
//   A        byte address
//   WD       store data
//   RD       load data, corrected on single error
//   s_err    corrected single-bit error on this load
//   d_err    uncorrectable error on this load
interface secded_dmem_responder_if;
  import secded_pkg::*;

  logic              WE;
  logic              RE;
  logic [31:0]       A;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] RD;
  logic              s_err;
  logic              d_err;

  modport master (output WE, RE, A, WD, input RD, s_err, d_err);
  modport slave  (input WE, RE, A, WD, output RD, s_err, d_err);

endinterface

// File: rtl/secded_codec.sv
// Combinational SECDED decoder.
//   cw         raw codeword read from the array
//   data       data field of the corrected codeword (raw field on d_err)
//   corr_cw    codeword with a single error flipped back (cw otherwise)
//   s_err_raw  single-bit error found (ungated)
//   d_err_raw  uncorrectable error found (ungated)
module secded_codec
  import secded_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   corr_cw,
  output logic              s_err_raw,
  output logic              d_err_raw
);

  logic [PAR_N-1:0] syn;
  logic             par;

  generate
    for (genvar gi = 0; gi < PAR_N; gi++) begin : g_syn
      assign syn[gi] = ^(cw & PMASK[gi]);
    end
  endgenerate

  assign par = ^cw;

  // Odd overall parity means an odd number of flips; a syndrome pointing
  // inside the codeword is taken as one flip (syndrome 0 = the parity bit).
  // A syndrome beyond position 38 cannot come from a single flip.
  always_comb begin
    s_err_raw = 1'b0;
    d_err_raw = 1'b0;
    corr_cw   = cw;
    if (par) begin
      if (syn <= PAR_N'(MAX_POS)) begin
        s_err_raw = 1'b1;
        corr_cw   = cw ^ (CW_W'(1) << syn);
      end else begin
        d_err_raw = 1'b1;
      end
    end else if (syn != '0) begin
      d_err_raw = 1'b1;
    end
  end

  assign data = extract_data(corr_cw);

endmodule

// File: rtl/secded_dmem_responder.sv
// SECDED-protected word-addressed data RAM answering the MEM stage.
// Loads are combinational: RD/s_err/d_err follow array[A] in the same cycle.
// Corrected words are written back by a one-entry scrub buffer in the first
// cycle without a store; error counters saturate.
//   clk, rst       clock, asynchronous active-low reset
//   bus            MEM-stage bus (slave side)
//   inj_en/mask    XOR mask applied to the codeword stored this cycle
//   clr_cnt        synchronous clear of s_cnt, d_cnt, err_addr
//   s_cnt, d_cnt   saturating counts of corrected / uncorrectable loads
//   err_addr       word index of the most recent flagged load
//   scrub_pending  corrected codeword waiting for write-back
module secded_dmem_responder
  import secded_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  secded_dmem_responder_if.slave  bus,
  input  logic                    inj_en,
  input  logic [CW_W-1:0]         inj_mask,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        s_cnt,
  output logic [CNT_W-1:0]        d_cnt,
  output logic [ADDR_W-1:0]       err_addr,
  output logic                    scrub_pending
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CW_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              unused_addr_bits;
  logic [CW_W-1:0]   rd_cw, corr_cw;
  logic [DATA_W-1:0] rd_data;
  logic              s_raw, d_raw, s_q, d_q;

  scrub_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] pend_idx_reg, pend_idx_next;
  logic [CW_W-1:0]   pend_cw_reg, pend_cw_next;
  logic              scrub_commit;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [CW_W-1:0]   wr_cw;

  logic [CNT_W-1:0]  s_cnt_reg, s_cnt_next, d_cnt_reg, d_cnt_next;
  logic [ADDR_W-1:0] err_addr_reg, err_addr_next;

  // Address wraps: only the word-index bits matter.
  assign idx              = bus.A[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.A[31:ADDR_W+2], bus.A[1:0]};

  assign rd_cw = mem[idx];

  secded_codec u_codec (
    .cw        (rd_cw),
    .data      (rd_data),
    .corr_cw   (corr_cw),
    .s_err_raw (s_raw),
    .d_err_raw (d_raw)
  );

  // A store in the same cycle takes precedence over the load.
  assign s_q       = bus.RE & ~bus.WE & s_raw;
  assign d_q       = bus.RE & ~bus.WE & d_raw;
  assign bus.RD    = rd_data;
  assign bus.s_err = s_q;
  assign bus.d_err = d_q;

  // The scrub write-back only uses cycles the pipeline leaves free.
  assign scrub_commit = (state_reg == SCRUB_PEND) && !bus.WE;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = idx;
    wr_cw  = secded_encode(bus.WD) ^ (inj_en ? inj_mask : '0);
    if (bus.WE) begin
      wr_en = 1'b1;
    end else if (scrub_commit) begin
      wr_en  = 1'b1;
      wr_idx = pend_idx_reg;
      wr_cw  = pend_cw_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_cw;
    end
  end

  // A load in PEND always happens in a commit cycle (WE=0), so any new
  // single error seen there is dropped; it is rediscovered on a later load.
  always_comb begin
    state_next    = state_reg;
    pend_idx_next = pend_idx_reg;
    pend_cw_next  = pend_cw_reg;
    case (state_reg)
      SCRUB_IDLE: begin
        if (s_q) begin
          state_next    = SCRUB_PEND;
          pend_idx_next = idx;
          pend_cw_next  = corr_cw;
        end
      end
      SCRUB_PEND: begin
        // Commit, or a store to the same word makes the saved copy stale.
        if (!bus.WE || (idx == pend_idx_reg)) begin
          state_next = SCRUB_IDLE;
        end
      end
      default: state_next = SCRUB_IDLE;
    endcase
  end

  always_comb begin
    s_cnt_next    = s_cnt_reg;
    d_cnt_next    = d_cnt_reg;
    err_addr_next = err_addr_reg;
    if (clr_cnt) begin
      s_cnt_next    = '0;
      d_cnt_next    = '0;
      err_addr_next = '0;
    end else begin
      if (s_q && (s_cnt_reg != CNT_MAX)) s_cnt_next = s_cnt_reg + CNT_W'(1);
      if (d_q && (d_cnt_reg != CNT_MAX)) d_cnt_next = d_cnt_reg + CNT_W'(1);
      if (s_q || d_q) err_addr_next = idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= SCRUB_IDLE;
      pend_idx_reg <= '0;
      pend_cw_reg  <= '0;
      s_cnt_reg    <= '0;
      d_cnt_reg    <= '0;
      err_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pend_idx_reg <= pend_idx_next;
      pend_cw_reg  <= pend_cw_next;
      s_cnt_reg    <= s_cnt_next;
      d_cnt_reg    <= d_cnt_next;
      err_addr_reg <= err_addr_next;
    end
  end

  assign s_cnt         = s_cnt_reg;
  assign d_cnt         = d_cnt_reg;
  assign err_addr      = err_addr_reg;
  assign scrub_pending = (state_reg == SCRUB_PEND);

endmodule

// File: tb/tb_secded_dmem_responder.sv
// Self-checking bench for secded_dmem_responder (CNT_W=2 so saturation is
// reachable). Table rows are applied one per cycle; expected results are
// queued when a row is driven and popped after the clock edge. The reset
// during a pending scrub is a hand-written sequence.
module tb_secded_dmem_responder;
  import secded_pkg::*;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 2;

  localparam logic [CW_W-1:0] ONE   = CW_W'(1);
  localparam logic [CW_W-1:0] NOM   = '0;
  localparam logic [CW_W-1:0] M_S5  = ONE << 5;
  localparam logic [CW_W-1:0] M_DBL = (ONE << 3) | (ONE << 9);
  localparam logic [CW_W-1:0] M_P0  = ONE;
  localparam logic [CW_W-1:0] M_MSB = ONE << 38;
  localparam logic [CW_W-1:0] M_P1  = ONE << 1;
  localparam logic [CW_W-1:0] M_TRI = (ONE << 32) | (ONE << 16) | (ONE << 8);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              inj_en = 1'b0;
  logic [CW_W-1:0]   inj_mask = '0;
  logic              clr_cnt = 1'b0;
  logic [CNT_W-1:0]  s_cnt, d_cnt;
  logic [ADDR_W-1:0] err_addr;
  logic              scrub_pending;

  secded_dmem_responder_if bus ();

  secded_dmem_responder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .inj_en        (inj_en),
    .inj_mask      (inj_mask),
    .clr_cnt       (clr_cnt),
    .s_cnt         (s_cnt),
    .d_cnt         (d_cnt),
    .err_addr      (err_addr),
    .scrub_pending (scrub_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              we, re;
    logic [31:0]       a, wd;
    logic              inj;
    logic [CW_W-1:0]   mask;
    logic              clr;
    logic              chk_rd;
    logic [31:0]       rd;
    logic              s, d;
    logic [CNT_W-1:0]  sc, dc;
    logic [ADDR_W-1:0] ea;
    logic              pend;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input string name, input int we, input int re,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int inj, input logic [CW_W-1:0] mask, input int clr,
                              input int chk_rd, input logic [31:0] rd, input int s, input int d,
                              input int sc, input int dc, input int ea, input int pend);
    vec_t v;
    v.name = name;  v.we = (we != 0);  v.re = (re != 0);
    v.a = a;  v.wd = wd;  v.inj = (inj != 0);  v.mask = mask;  v.clr = (clr != 0);
    v.chk_rd = (chk_rd != 0);  v.rd = rd;  v.s = (s != 0);  v.d = (d != 0);
    v.sc = CNT_W'(sc);  v.dc = CNT_W'(dc);  v.ea = ADDR_W'(ea);  v.pend = (pend != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    vec_t        e;
    logic [31:0] rd_s;
    logic        s_s, d_s;
    @(negedge clk);
    bus.WE = v.we;  bus.RE = v.re;  bus.A = v.a;  bus.WD = v.wd;
    inj_en = v.inj;  inj_mask = v.mask;  clr_cnt = v.clr;
    exp_q.push_back(v);
    #1;
    rd_s = bus.RD;  s_s = bus.s_err;  d_s = bus.d_err;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.chk_rd) check({e.name, ".rd"}, 64'(rd_s), 64'(e.rd));
    check({e.name, ".s_err"}, 64'(s_s), 64'(e.s));
    check({e.name, ".d_err"}, 64'(d_s), 64'(e.d));
    check({e.name, ".s_cnt"}, 64'(s_cnt), 64'(e.sc));
    check({e.name, ".d_cnt"}, 64'(d_cnt), 64'(e.dc));
    check({e.name, ".err_addr"}, 64'(err_addr), 64'(e.ea));
    check({e.name, ".scrub_pending"}, 64'(scrub_pending), 64'(e.pend));
    $display("%-16s we=%0b re=%0b a=%h wd=%h rd=%h s=%0b d=%0b s_cnt=%0d d_cnt=%0d err_addr=%0d pend=%0b",
             e.name, e.we, e.re, e.a, e.wd, rd_s, s_s, d_s, s_cnt, d_cnt, err_addr, scrub_pending);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 200000");
    $fatal(1);
  end

  initial begin
    bus.WE = 1'b0;  bus.RE = 1'b0;  bus.A = '0;  bus.WD = '0;

    //               name             we re a            wd           inj mask  clr chk rd           s d sc dc ea   pend
    tv.push_back(mk("wr_clean",       1, 0, 32'h10,      32'hDEADBEEF, 0, NOM,   0, 0, 32'h0,       0, 0, 0, 0, 0,   0));
    tv.push_back(mk("rd_clean",       0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0,   0));
    tv.push_back(mk("wr_inj_single",  1, 0, 32'h10,      32'hDEADBEEF, 1, M_S5,  0, 0, 32'h0,       0, 0, 0, 0, 0,   0));
    tv.push_back(mk("rd_single",      0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'hDEADBEEF, 1, 0, 1, 0, 4,   1));
    tv.push_back(mk("idle_commit",    0, 0, 32'h10,      32'h0,        0, NOM,   0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 4,   0));
    tv.push_back(mk("rd_scrubbed",    0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 4,   0));
    tv.push_back(mk("wr_inj_double",  1, 0, 32'h10,      32'hDEADBEEF, 1, M_DBL, 0, 0, 32'h0,       0, 0, 1, 0, 4,   0));
    tv.push_back(mk("rd_double",      0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'hDEADBEFE, 0, 1, 1, 1, 4,   0));
    tv.push_back(mk("rd_double_again",0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'hDEADBEFE, 0, 1, 1, 2, 4,   0));
    tv.push_back(mk("wr_inj_single2", 1, 0, 32'h10,      32'hDEADBEEF, 1, M_S5,  0, 0, 32'h0,       0, 0, 1, 2, 4,   0));
    tv.push_back(mk("rd_single2",     0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'hDEADBEEF, 1, 0, 2, 2, 4,   1));
    tv.push_back(mk("wr_cancel",      1, 0, 32'h10,      32'h12345678, 0, NOM,   0, 0, 32'h0,       0, 0, 2, 2, 4,   0));
    tv.push_back(mk("rd_new",         0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'h12345678, 0, 0, 2, 2, 4,   0));
    tv.push_back(mk("wr_inj_parity",  1, 0, 32'h20,      32'hA5A5A5A5, 1, M_P0,  0, 0, 32'h0,       0, 0, 2, 2, 4,   0));
    tv.push_back(mk("rd_single3",     0, 1, 32'h20,      32'h0,        0, NOM,   0, 1, 32'hA5A5A5A5, 1, 0, 3, 2, 8,   1));
    tv.push_back(mk("wr_other",       1, 0, 32'h40,      32'h0F0F0F0F, 0, NOM,   0, 0, 32'h0,       0, 0, 3, 2, 8,   1));
    tv.push_back(mk("idle_commit2",   0, 0, 32'h20,      32'h0,        0, NOM,   0, 1, 32'hA5A5A5A5, 0, 0, 3, 2, 8,   0));
    tv.push_back(mk("rd_scrubbed2",   0, 1, 32'h20,      32'h0,        0, NOM,   0, 1, 32'hA5A5A5A5, 0, 0, 3, 2, 8,   0));
    tv.push_back(mk("rd_other",       0, 1, 32'h40,      32'h0,        0, NOM,   0, 1, 32'h0F0F0F0F, 0, 0, 3, 2, 8,   0));
    tv.push_back(mk("wr_inj_msb",     1, 0, 32'h10,      32'h12345678, 1, M_MSB, 0, 0, 32'h0,       0, 0, 3, 2, 8,   0));
    tv.push_back(mk("rd_sat",         0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'h12345678, 1, 0, 3, 2, 4,   1));
    tv.push_back(mk("rd_clr",         0, 1, 32'h10,      32'h0,        0, NOM,   1, 1, 32'h12345678, 1, 0, 0, 0, 0,   0));
    tv.push_back(mk("rd_after_clr",   0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'h12345678, 0, 0, 0, 0, 0,   0));
    tv.push_back(mk("wr_wrap",        1, 0, 32'h410,     32'hCAFEF00D, 0, NOM,   0, 0, 32'h0,       0, 0, 0, 0, 0,   0));
    tv.push_back(mk("rd_wrap",        0, 1, 32'hFFFFFC10, 32'h0,       0, NOM,   0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0,   0));
    tv.push_back(mk("wr_inj_p1",      1, 0, 32'h10,      32'hCAFEF00D, 1, M_P1,  0, 0, 32'h0,       0, 0, 0, 0, 0,   0));
    tv.push_back(mk("we_re_gate",     1, 1, 32'h10,      32'h55AA55AA, 0, NOM,   0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0,   0));
    tv.push_back(mk("rd_we_re",       0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'h55AA55AA, 0, 0, 0, 0, 0,   0));
    tv.push_back(mk("wr_inj_triple",  1, 0, 32'h80,      32'h0BADF00D, 1, M_TRI, 0, 0, 32'h0,       0, 0, 0, 0, 0,   0));
    tv.push_back(mk("rd_triple",      0, 1, 32'h80,      32'h0,        0, NOM,   0, 1, 32'h0BADF00D, 0, 1, 0, 1, 32,  0));
    tv.push_back(mk("t6_wr_inj",      1, 0, 32'h10,      32'h600DCAFE, 1, M_S5,  0, 0, 32'h0,       0, 0, 0, 1, 32,  0));
    tv.push_back(mk("t6_rd_single",   0, 1, 32'h10,      32'h0,        0, NOM,   0, 1, 32'h600DCAFE, 1, 0, 1, 1, 4,   1));

    // Reset state while rst is held low from time 0.
    #2;
    check("reset.scrub_pending", 64'(scrub_pending), 64'(0));
    check("reset.s_cnt", 64'(s_cnt), 64'(0));
    check("reset.d_cnt", 64'(d_cnt), 64'(0));
    check("reset.err_addr", 64'(err_addr), 64'(0));
    $display("reset            s_cnt=%0d d_cnt=%0d err_addr=%0d pend=%0b", s_cnt, d_cnt, err_addr, scrub_pending);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) apply(tv[i]);

    // Asynchronous reset while a scrub is pending: state clears at once,
    // the load path keeps decoding the still-uncorrected array word.
    @(negedge clk);
    bus.WE = 1'b0;  bus.RE = 1'b1;  bus.A = 32'h10;  inj_en = 1'b0;  clr_cnt = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_async.scrub_pending", 64'(scrub_pending), 64'(0));
    check("t6_async.s_cnt", 64'(s_cnt), 64'(0));
    check("t6_async.d_cnt", 64'(d_cnt), 64'(0));
    check("t6_async.err_addr", 64'(err_addr), 64'(0));
    check("t6_async.s_err", 64'(bus.s_err), 64'(1));
    check("t6_async.rd", 64'(bus.RD), 64'(32'h600DCAFE));
    $display("t6_async_rst     rd=%h s=%0b s_cnt=%0d d_cnt=%0d err_addr=%0d pend=%0b",
             bus.RD, bus.s_err, s_cnt, d_cnt, err_addr, scrub_pending);
    @(posedge clk);
    #1;
    check("t6_held.scrub_pending", 64'(scrub_pending), 64'(0));
    check("t6_held.s_cnt", 64'(s_cnt), 64'(0));
    $display("t6_rst_held      s_cnt=%0d pend=%0b", s_cnt, scrub_pending);
    @(negedge clk);
    rst = 1'b1;
    bus.RE = 1'b0;

    apply(mk("t6_reread",      0, 1, 32'h10, 32'h0, 0, NOM, 0, 1, 32'h600DCAFE, 1, 0, 1, 0, 4, 1));
    apply(mk("t6_commit",      0, 0, 32'h10, 32'h0, 0, NOM, 0, 1, 32'h600DCAFE, 0, 0, 1, 0, 4, 0));
    apply(mk("t6_clean",       0, 1, 32'h10, 32'h0, 0, NOM, 0, 1, 32'h600DCAFE, 0, 0, 1, 0, 4, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
